// File: rtl/fir_pkg.sv
// Shared widths and saturation helper for the FIR output path.
package fir_pkg;

  localparam int IN_W_DEF  = 32;
  localparam int OUT_W_DEF = 16;

  localparam logic signed [OUT_W_DEF-1:0] OUT_MAX = {1'b0, {(OUT_W_DEF-1){1'b1}}};
  localparam logic signed [OUT_W_DEF-1:0] OUT_MIN = {1'b1, {(OUT_W_DEF-1){1'b0}}};

  // Clamp a signed value into the range of a signed 'width'-bit number.
  // The result stays 64 bits wide so callers can both compare it against
  // the unclamped value and truncate it to their own output width.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] value,
                                                  input int unsigned       width);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (width - 1));
    if (value > max_v) begin
      return max_v;
    end else if (value < min_v) begin
      return min_v;
    end else begin
      return value;
    end
  endfunction

endpackage

// File: rtl/fir_decim_out_buffer_sync_fifo.sv
// First-word-fall-through FIFO; a push into a full FIFO is accepted only
// when a pop frees the head slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == ($clog2(DEPTH)+1)'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // Empty FIFO presents zero so the output never shows stale or unknown data.
  assign dout = empty ? '0 : mem[rd_ptr];

  // Storage write; when full with a pop, the write lands in the slot being freed.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fir_decim_out_buffer.sv
// FIR output conditioning: drops pipeline warm-up samples, decimates,
// rounds/shifts/saturates to OUT_W and buffers results for a valid/ready sink.
module fir_decim_out_buffer
  import fir_pkg::*;
#(
  parameter int IN_W   = IN_W_DEF,
  parameter int OUT_W  = OUT_W_DEF,
  parameter int DECIM  = 4,
  parameter int SHIFT  = 4,
  parameter int WARMUP = 8,
  parameter int DEPTH  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [IN_W-1:0]        y_in,
  input  logic                   in_valid,
  output logic [OUT_W-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   sat_flag,
  output logic                   overflow,
  input  logic                   clr_flags
);

  localparam int WW      = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
  localparam int PW      = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int BIAS_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [IN_W:0] BIAS = (SHIFT > 0) ? ((IN_W+1)'(1) << BIAS_SH) : '0;

  logic [WW-1:0]          warm_cnt;
  logic [PW-1:0]          phase;
  logic                   warm_done;
  logic                   keep;
  logic signed [IN_W:0]   sum;
  logic signed [IN_W:0]   t;
  logic signed [63:0]     t_wide;
  logic signed [63:0]     clamped;
  logic                   clamp_hit;
  logic                   s1_valid;
  logic [OUT_W-1:0]       s1_data;
  logic                   pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   ovf_event;

  assign warm_done = (warm_cnt >= WW'(WARMUP));
  assign keep      = in_valid && warm_done && (phase == '0);

  // Round-half-up scaling in one extra bit of headroom, then clamp to OUT_W.
  always_comb begin
    sum       = $signed({y_in[IN_W-1], y_in}) + $signed(BIAS);
    t         = sum >>> SHIFT;
    t_wide    = t;
    clamped   = saturate(t_wide, OUT_W);
    clamp_hit = (clamped != t_wide);
  end

  // Warm-up discard then decimation phase; both hold while in_valid is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      warm_cnt <= '0;
      phase    <= '0;
    end else if (in_valid) begin
      if (!warm_done) begin
        warm_cnt <= warm_cnt + 1'b1;
      end else if (phase == PW'(DECIM - 1)) begin
        phase <= '0;
      end else begin
        phase <= phase + 1'b1;
      end
    end
  end

  // Stage-1 register holding the scaled sample headed for the FIFO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= keep;
      if (keep) begin
        s1_data <= OUT_W'(clamped);
      end
    end
  end

  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign ovf_event = s1_valid && fifo_full && !pop;

  // Sticky status flags; a new event in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sat_flag <= 1'b0;
      overflow <= 1'b0;
    end else begin
      sat_flag <= (sat_flag && !clr_flags) || (keep && clamp_hit);
      overflow <= (overflow && !clr_flags) || ovf_event;
    end
  end

  sync_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (s1_valid),
    .pop   (pop),
    .din   (s1_data),
    .dout  (out_data),
    .count (level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule
